// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the program-counter sequencer.
//   PC_WIDTH_DEF     - default PC / address width
//   RAS_DEPTH_DEF    - default return-address-stack depth
//   RESET_VECTOR_DEF - default PC value loaded on reset
//   pc_sel_e         - source of the next PC value
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 8;
  localparam int unsigned RAS_DEPTH_DEF    = 4;
  localparam int unsigned RESET_VECTOR_DEF = 0;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_RET    = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack (LIFO), DEPTH entries of WIDTH bits.
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset; empties the stack
//   push  - write wdata on top (ignored while full)
//   pop   - discard top entry (ignored while empty)
//   wdata - value to push
//   top   - current top entry (don't-care while empty)
//   empty - stack holds no entries
//   full  - stack holds DEPTH entries
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEF,
  parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // One extra bit so that "DEPTH entries" is distinguishable from "0 entries".
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [IDX_W-1:0] top_idx_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (ptr_r == {PTR_W{1'b0}});
  assign full      = (ptr_r == PTR_W'(DEPTH));
  assign top_idx_s = ptr_r[IDX_W-1:0] - IDX_W'(1);
  assign top       = mem_r[top_idx_s];

  // Guard the pointer against overflow/underflow locally as well.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (push && !full) begin
      do_push_s = 1'b1;
    end else if (pop && !empty) begin
      do_pop_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end
  end

  // Stack pointer and storage update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[ptr_r[IDX_W-1:0]] <= wdata;
      ptr_r                   <= ptr_r + PTR_W'(1);
    end else if (do_pop_s) begin
      ptr_r <= ptr_r - PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with stall, absolute jump,
// relative branch and call/return through an internal return-address stack.
//   clk           - system clock, rising edge
//   rst           - asynchronous active-low reset
//   en            - advance enable; 0 holds every piece of state
//   jump_valid    - load jump_target (highest priority)
//   jump_target   - absolute target address
//   call          - with jump_valid, push pc_plus as return address
//   ret           - pop return address into pc
//   branch_valid  - add branch_offset to pc
//   branch_offset - two's-complement relative offset
//   pc            - registered fetch address
//   pc_plus       - pc + STEP, wrapped
//   ras_empty     - return stack holds no entries
//   ras_full      - return stack holds RAS_DEPTH entries
//   ras_err       - sticky overflow/underflow flag, cleared only by reset
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned          STEP         = 1,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
  parameter int unsigned          RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                jump_valid,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                call,
  input  logic                ret,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err
);

  logic [PC_WIDTH-1:0] pc_r;
  logic                ras_err_r;
  logic [PC_WIDTH-1:0] pc_plus_s;
  logic [PC_WIDTH-1:0] branch_pc_s;
  logic [PC_WIDTH-1:0] ras_top_s;
  logic [PC_WIDTH-1:0] pc_next_s;
  logic                push_s;
  logic                pop_s;
  logic                err_set_s;
  pc_sel_e             sel_s;

  // Sums are truncated to PC_WIDTH, so wrap-around is implicit.
  assign pc_plus_s   = pc_r + PC_WIDTH'(STEP);
  assign branch_pc_s = pc_r + branch_offset;

  assign pc      = pc_r;
  assign pc_plus = pc_plus_s;
  assign ras_err = ras_err_r;

  pc_ras #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (pc_plus_s),
    .top   (ras_top_s),
    .empty (ras_empty),
    .full  (ras_full)
  );

  // Priority select: jump > ret > branch > sequential. Underflowing ret
  // falls back to sequential flow; overflowing call still jumps.
  always_comb begin
    sel_s     = SEL_SEQ;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    if (en) begin
      if (jump_valid) begin
        sel_s = SEL_JUMP;
        if (call) begin
          if (ras_full) begin
            err_set_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          push_s = 1'b0;
        end
      end else if (ret) begin
        if (ras_empty) begin
          sel_s     = SEL_SEQ;
          err_set_s = 1'b1;
        end else begin
          sel_s = SEL_RET;
          pop_s = 1'b1;
        end
      end else if (branch_valid) begin
        sel_s = SEL_BRANCH;
      end else begin
        sel_s = SEL_SEQ;
      end
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-pc multiplexer.
  always_comb begin
    pc_next_s = pc_plus_s;
    case (sel_s)
      SEL_JUMP:   pc_next_s = jump_target;
      SEL_RET:    pc_next_s = ras_top_s;
      SEL_BRANCH: pc_next_s = branch_pc_s;
      SEL_SEQ:    pc_next_s = pc_plus_s;
      default:    pc_next_s = pc_plus_s;
    endcase
  end

  // PC register and sticky error flag; both hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r      <= RESET_VECTOR;
      ras_err_r <= 1'b0;
    end else if (en) begin
      pc_r      <= pc_next_s;
      ras_err_r <= ras_err_r | err_set_s;
    end else begin
      pc_r      <= pc_r;
      ras_err_r <= ras_err_r;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       jump_valid = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic       branch_valid = 1'b0;
  logic [7:0] branch_offset = 8'h00;
  logic [7:0] pc;
  logic [7:0] pc_plus;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .branch_valid  (branch_valid),
    .branch_offset (branch_offset),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_err       (ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       jv;
    logic [7:0] jt;
    logic       call;
    logic       ret;
    logic       bv;
    logic [7:0] bo;
    logic [7:0] epc;
    logic       ee;
    logic       ef;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference state: plain queue as the stack.
  logic [7:0] mpc;
  logic [7:0] mstk[$];
  logic       merr;

  task automatic add(input logic e, input logic jv, input logic [7:0] jt, input logic c,
                     input logic r, input logic bv, input logic [7:0] bo,
                     input logic [7:0] epc, input logic ee, input logic ef, input logic er);
    vec_t v;
    v.en = e; v.jv = jv; v.jt = jt; v.call = c; v.ret = r; v.bv = bv; v.bo = bo;
    v.epc = epc; v.ee = ee; v.ef = ef; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] epc, input logic ee,
                       input logic ef, input logic er);
    logic [7:0] eplus;
    eplus = epc + 8'd1;
    n_vec++;
    if (pc !== epc || pc_plus !== eplus || ras_empty !== ee || ras_full !== ef || ras_err !== er) begin
      n_err++;
      $display("FAIL %s: got pc=%h pc_plus=%h empty=%b full=%b err=%b, want pc=%h pc_plus=%h empty=%b full=%b err=%b",
               nm, pc, pc_plus, ras_empty, ras_full, ras_err, epc, eplus, ee, ef, er);
    end
  endtask

  task automatic drive(input logic e, input logic jv, input logic [7:0] jt, input logic c,
                       input logic r, input logic bv, input logic [7:0] bo);
    en = e; jump_valid = jv; jump_target = jt; call = c; ret = r;
    branch_valid = bv; branch_offset = bo;
  endtask

  // Reference model step from the behavioural rules.
  task automatic model_step(input logic e, input logic jv, input logic [7:0] jt, input logic c,
                            input logic r, input logic bv, input logic [7:0] bo);
    if (e) begin
      if (jv) begin
        if (c) begin
          if (mstk.size() == DEPTH) merr = 1'b1;
          else mstk.push_back(mpc + 8'd1);
        end
        mpc = jt;
      end else if (r) begin
        if (mstk.size() == 0) begin
          merr = 1'b1;
          mpc  = mpc + 8'd1;
        end else begin
          mpc = mstk.pop_back();
        end
      end else if (bv) begin
        mpc = mpc + bo;
      end else begin
        mpc = mpc + 8'd1;
      end
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;

    // free run
    add(1,0,8'h00,0,0,0,8'h00, 8'h01,1,0,0);
    add(1,0,8'h00,0,0,0,8'h00, 8'h02,1,0,0);
    add(1,0,8'h00,0,0,0,8'h00, 8'h03,1,0,0);
    // stall and wrap; stalled call/ret must be ignored
    add(1,1,8'hFE,0,0,0,8'h00, 8'hFE,1,0,0);
    add(1,0,8'h00,0,0,0,8'h00, 8'hFF,1,0,0);
    add(0,0,8'h00,0,0,0,8'h00, 8'hFF,1,0,0);
    add(0,1,8'h55,1,1,1,8'h10, 8'hFF,1,0,0);
    add(1,0,8'h00,0,0,0,8'h00, 8'h00,1,0,0);
    add(1,0,8'h00,0,0,0,8'h00, 8'h01,1,0,0);
    // branch and priority (ret on empty stack loses to jump: no error)
    add(1,1,8'h10,0,0,0,8'h00, 8'h10,1,0,0);
    add(1,0,8'h00,0,0,1,8'hF8, 8'h08,1,0,0);
    add(1,1,8'h40,0,1,1,8'h04, 8'h40,1,0,0);
    // call / return; call without jump does nothing
    add(1,1,8'h20,0,0,0,8'h00, 8'h20,1,0,0);
    add(1,1,8'h50,1,0,0,8'h00, 8'h50,0,0,0);
    add(1,0,8'h00,0,0,0,8'h00, 8'h51,0,0,0);
    add(1,0,8'h00,0,0,0,8'h00, 8'h52,0,0,0);
    add(1,0,8'h00,0,1,1,8'h30, 8'h21,1,0,0);
    add(1,0,8'h00,1,0,0,8'h00, 8'h22,1,0,0);
    // overflow / underflow
    add(1,1,8'h00,0,0,0,8'h00, 8'h00,1,0,0);
    add(1,1,8'h30,1,0,0,8'h00, 8'h30,0,0,0);
    add(1,1,8'h31,1,0,0,8'h00, 8'h31,0,0,0);
    add(1,1,8'h32,1,0,0,8'h00, 8'h32,0,0,0);
    add(1,1,8'h33,1,0,0,8'h00, 8'h33,0,1,0);
    add(1,1,8'h34,1,0,0,8'h00, 8'h34,0,1,1);
    add(1,0,8'h00,0,1,0,8'h00, 8'h33,0,0,1);
    add(1,0,8'h00,0,1,0,8'h00, 8'h32,0,0,1);
    add(1,0,8'h00,0,1,0,8'h00, 8'h31,0,0,1);
    add(1,0,8'h00,0,1,0,8'h00, 8'h01,1,0,1);
    add(1,0,8'h00,0,1,0,8'h00, 8'h02,1,0,1);
    // negative branch wrap, then increment wrap
    add(1,0,8'h00,0,0,1,8'hFC, 8'hFE,1,0,1);
    add(1,0,8'h00,0,0,0,8'h00, 8'hFF,1,0,1);
    add(1,0,8'h00,0,0,0,8'h00, 8'h00,1,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].jv, tbl[i].jt, tbl[i].call, tbl[i].ret, tbl[i].bv, tbl[i].bo);
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d]", i), tbl[i].epc, tbl[i].ee, tbl[i].ef, tbl[i].er);
    end

    // Asynchronous reset between edges
    drive(1'b1, 1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("pre_async", 8'h37, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("async_hold", 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;

    // Randomised run against the reference model
    mpc = 8'h00;
    mstk.delete();
    merr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic       e, jv, c, r, bv;
      logic [7:0] jt, bo;
      e  = ($urandom_range(0, 99) < 85);
      jv = ($urandom_range(0, 99) < 30);
      c  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 35);
      bv = ($urandom_range(0, 99) < 30);
      jt = 8'($urandom);
      bo = 8'($urandom);
      drive(e, jv, jt, c, r, bv, bo);
      model_step(e, jv, jt, c, r, bv, bo);
      @(posedge clk);
      #1;
      check($sformatf("rand[%0d]", i), mpc, (mstk.size() == 0), (mstk.size() == DEPTH), merr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
